// File: rtl/brick_field.sv
// brick_field: renders the brick wall, detects ball/brick contact during the scan,
// retires at most one brick per frame, requests ball bounces and keeps score.
module brick_field #(
   parameter  int COLS     = 8,
   parameter  int ROWS     = 4,
   parameter  int BRICK_W  = 64,
   parameter  int BRICK_H  = 16,
   parameter  int GAP      = 2,
   parameter  int ORIGIN_X = 64,
   parameter  int ORIGIN_Y = 48,
   parameter  int POINTS   = 10,
   localparam int NB       = ROWS * COLS,
   localparam int LW       = $clog2(NB + 1),
   localparam int IW       = (NB > 1) ? $clog2(NB) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [9:0]    CounterX,
   input  logic [8:0]    CounterY,
   input  logic          frame_tick,
   input  logic [9:0]    ball_x,
   input  logic [8:0]    ball_y,
   input  logic          restart,
   output logic          brick_pixel,
   output logic          hit_x,
   output logic          hit_y,
   output logic [15:0]   score,
   output logic [LW-1:0] bricks_left,
   output logic          level_clear
);
   localparam int XS = $clog2(BRICK_W);
   localparam int YS = $clog2(BRICK_H);

   typedef enum logic [1:0] {PLAY, CLEAR, RELOAD} state_t;
   typedef struct packed {
      logic          face;
      logic [IW-1:0] idx;
   } cell_t;

   // face: point lies on the lit face of some grid cell; idx is only meaningful then
   function automatic cell_t locate(input logic [11:0] x, input logic [11:0] y);
      int    dx;
      int    dy;
      cell_t c;
      dx     = int'(x) - ORIGIN_X;
      dy     = int'(y) - ORIGIN_Y;
      c.face = (dx >= 0) && (dx < COLS * BRICK_W) && (dy >= 0) && (dy < ROWS * BRICK_H)
               && ((dx & (BRICK_W - 1)) < (BRICK_W - GAP))
               && ((dy & (BRICK_H - 1)) < (BRICK_H - GAP));
      c.idx  = IW'(((dy >>> YS) * COLS) + (dx >>> XS));
      return c;
   endfunction

   function automatic logic [15:0] sat_add(input logic [15:0] s);
      logic [16:0] t;
      t = {1'b0, s} + 17'(POINTS);
      return t[16] ? 16'hFFFF : t[15:0];
   endfunction

   state_t        state_q, state_d;
   logic [NB-1:0] alive_q, alive_d;
   logic [LW-1:0] left_q, left_d;
   logic [15:0]   score_q, score_d;
   logic          hit_x_q, hit_x_d, hit_y_q, hit_y_d;
   logic          pix_q, pix_d;
   logic          latch_full_q, latch_full_d;
   logic          latch_ax_q, latch_ax_d, latch_ay_q, latch_ay_d;
   logic [IW-1:0] latch_idx_q, latch_idx_d;
   logic          pend_q, pend_d, pend_ax_q, pend_ax_d, pend_ay_q, pend_ay_d;
   logic [IW-1:0] pend_idx_q, pend_idx_d;

   cell_t       cur;
   logic [11:0] cx, cy, bx, by;
   logic        lit_now, m_x, m_y, probe_ok;

   assign cx = {2'b00, CounterX};
   assign cy = {3'b000, CounterY};
   assign bx = {2'b00, ball_x};
   assign by = {3'b000, ball_y};

   always_comb begin
      cur      = locate(cx, cy);
      lit_now  = cur.face && alive_q[cur.idx];
      m_y      = (cx == bx + 12'd8) && ((cy == by) || (cy == by + 12'd16));
      m_x      = (cy == by + 12'd8) && ((cx == bx) || (cx == bx + 12'd16));
      probe_ok = (state_q == PLAY) && lit_now && !frame_tick && (m_x || m_y);
      pix_d    = lit_now;
   end

   // Hit latch: first brick touched this frame wins; repeat touches only add axes
   always_comb begin
      latch_full_d = latch_full_q;
      latch_idx_d  = latch_idx_q;
      latch_ax_d   = latch_ax_q;
      latch_ay_d   = latch_ay_q;
      if (frame_tick || (state_q != PLAY)) begin
         latch_full_d = 1'b0;
         latch_ax_d   = 1'b0;
         latch_ay_d   = 1'b0;
      end else if (probe_ok) begin
         if (!latch_full_q) begin
            latch_full_d = 1'b1;
            latch_idx_d  = cur.idx;
            latch_ax_d   = m_x;
            latch_ay_d   = m_y;
         end else if (latch_idx_q == cur.idx) begin
            latch_ax_d = latch_ax_q | m_x;
            latch_ay_d = latch_ay_q | m_y;
         end
      end
      pend_d     = frame_tick && (state_q == PLAY) && latch_full_q;
      pend_idx_d = latch_idx_q;
      pend_ax_d  = latch_ax_q;
      pend_ay_d  = latch_ay_q;
   end

   // Retirement is applied one cycle after frame_tick so a reset there cancels it
   always_comb begin
      state_d = state_q;
      alive_d = alive_q;
      left_d  = left_q;
      score_d = score_q;
      hit_x_d = 1'b0;
      hit_y_d = 1'b0;
      unique case (state_q)
         PLAY: begin
            if (pend_q) begin
               alive_d[pend_idx_q] = 1'b0;
               left_d              = left_q - LW'(1);
               score_d             = sat_add(score_q);
               hit_x_d             = pend_ax_q;
               hit_y_d             = pend_ay_q;
               if (left_q == LW'(1)) state_d = CLEAR;
            end
         end
         CLEAR: begin
            if (restart) state_d = RELOAD;
         end
         RELOAD: begin
            alive_d = '1;
            left_d  = LW'(NB);
            state_d = PLAY;
         end
         default: state_d = PLAY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= PLAY;
         alive_q      <= '1;
         left_q       <= LW'(NB);
         score_q      <= '0;
         hit_x_q      <= 1'b0;
         hit_y_q      <= 1'b0;
         pix_q        <= 1'b0;
         latch_full_q <= 1'b0;
         latch_ax_q   <= 1'b0;
         latch_ay_q   <= 1'b0;
         pend_q       <= 1'b0;
         pend_ax_q    <= 1'b0;
         pend_ay_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         alive_q      <= alive_d;
         left_q       <= left_d;
         score_q      <= score_d;
         hit_x_q      <= hit_x_d;
         hit_y_q      <= hit_y_d;
         pix_q        <= pix_d;
         latch_full_q <= latch_full_d;
         latch_ax_q   <= latch_ax_d;
         latch_ay_q   <= latch_ay_d;
         pend_q       <= pend_d;
         pend_ax_q    <= pend_ax_d;
         pend_ay_q    <= pend_ay_d;
      end
   end

   always_ff @(posedge clk) begin
      latch_idx_q <= latch_idx_d;
      pend_idx_q  <= pend_idx_d;
   end

   assign brick_pixel = pix_q;
   assign hit_x       = hit_x_q;
   assign hit_y       = hit_y_q;
   assign score       = score_q;
   assign bricks_left = left_q;
   assign level_clear = (state_q == CLEAR);

endmodule

// File: tb/tb_brick_field.sv
// Scoreboard bench for brick_field: stimulus queues expected pixels and hit pulses,
// a monitor process pops and compares them as the DUT presents them.
module tb_brick_field;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] counter_x = '0;
   logic [8:0] counter_y = '0;
   logic       frame_tick = 1'b0;
   logic [9:0] ball_x = '0;
   logic [8:0] ball_y = '0;
   logic       restart = 1'b0;
   logic       brick_pixel, hit_x, hit_y, level_clear;
   logic [15:0] score;
   logic [5:0]  bricks_left;

   always #5 clk = ~clk;

   brick_field dut (
      .clk(clk), .rst_n(rst_n), .CounterX(counter_x), .CounterY(counter_y),
      .frame_tick(frame_tick), .ball_x(ball_x), .ball_y(ball_y), .restart(restart),
      .brick_pixel(brick_pixel), .hit_x(hit_x), .hit_y(hit_y), .score(score),
      .bricks_left(bricks_left), .level_clear(level_clear)
   );

   typedef struct packed {
      logic        hx;
      logic        hy;
      logic [15:0] sc;
      logic [5:0]  bl;
   } hit_t;

   hit_t hit_q[$];
   logic pix_q[$];
   logic px_req = 1'b0;
   logic px_vld = 1'b0;
   int   total = 0;
   int   bad = 0;

   always @(posedge clk) px_vld <= px_req;

   // Monitor
   initial begin
      hit_t he;
      logic pe;
      forever begin
         @(negedge clk);
         if (px_vld) begin
            total++;
            if (pix_q.size() == 0) begin
               bad++;
               $display("FAIL pixel_extra got=%0b want=none", brick_pixel);
            end else begin
               pe = pix_q.pop_front();
               if (brick_pixel !== pe) begin
                  bad++;
                  $display("FAIL pixel x=%0d y=%0d got=%0b want=%0b", counter_x, counter_y, brick_pixel, pe);
               end
            end
         end
         if (hit_x || hit_y) begin
            total++;
            if (hit_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_pulse got hx=%0b hy=%0b score=%0d left=%0d want=no pulse",
                        hit_x, hit_y, score, bricks_left);
            end else begin
               he = hit_q.pop_front();
               if (hit_x !== he.hx || hit_y !== he.hy || score !== he.sc || bricks_left !== he.bl) begin
                  bad++;
                  $display("FAIL hit got hx=%0b hy=%0b score=%0d left=%0d want hx=%0b hy=%0b score=%0d left=%0d",
                           hit_x, hit_y, score, bricks_left, he.hx, he.hy, he.sc, he.bl);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; counter_x = '0; counter_y = '0; frame_tick = 1'b0; restart = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pix(input int x, input int y, input logic want);
      @(negedge clk);
      counter_x = 10'(x); counter_y = 9'(y); px_req = 1'b1;
      pix_q.push_back(want);
      @(negedge clk);
      px_req = 1'b0; counter_x = '0; counter_y = '0;
   endtask

   task automatic probe_at(input int x, input int y);
      @(negedge clk);
      counter_x = 10'(x); counter_y = 9'(y);
      @(negedge clk);
      counter_x = '0; counter_y = '0;
   endtask

   task automatic tick(input bit expect_hit, input logic hx, input logic hy,
                       input logic [15:0] sc, input logic [5:0] bl);
      hit_t h;
      h = '{hx: hx, hy: hy, sc: sc, bl: bl};
      @(negedge clk);
      frame_tick = 1'b1;
      if (expect_hit) hit_q.push_back(h);
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (4) @(negedge clk);
      check("pulse_arrived", 32'(hit_q.size()), 0);
      hit_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      // 1: reset values and grid geometry
      do_reset();
      check("rst_pixel", 32'(brick_pixel), 0);
      check("rst_hit_x", 32'(hit_x), 0);
      check("rst_hit_y", 32'(hit_y), 0);
      check("rst_score", 32'(score), 0);
      check("rst_left", 32'(bricks_left), 32);
      check("rst_clear", 32'(level_clear), 0);
      pix(64, 48, 1'b1);
      pix(125, 61, 1'b1);
      pix(126, 48, 1'b0);
      pix(64, 62, 1'b0);
      pix(63, 48, 1'b0);
      pix(576, 48, 1'b0);
      pix(575, 109, 1'b0);
      pix(573, 109, 1'b1);

      // 2: top probe on row3/col0
      ball_x = 10'd92; ball_y = 9'd109;
      probe_at(100, 109);
      probe_at(92, 117);
      probe_at(108, 117);
      tick(1'b1, 1'b0, 1'b1, 16'd10, 6'd31);
      pix(64, 96, 1'b0);
      pix(64, 80, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 16'd0, 6'd0);

      // 3: first brick in raster order wins, other brick ignored
      do_reset();
      ball_x = 10'd112; ball_y = 9'd48;
      probe_at(120, 48);
      probe_at(128, 56);
      probe_at(120, 64);
      tick(1'b1, 1'b0, 1'b1, 16'd10, 6'd31);
      pix(64, 48, 1'b0);
      pix(128, 48, 1'b1);
      pix(64, 64, 1'b1);
      // same brick touched on two axes -> both pulses
      ball_x = 10'd134; ball_y = 9'd49;
      probe_at(142, 49);
      probe_at(134, 57);
      tick(1'b1, 1'b1, 1'b1, 16'd20, 6'd30);

      // 4: clear the whole wall, then restart
      do_reset();
      k = 0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 8; c++) begin
            k++;
            ball_x = 10'(64 + 64 * c); ball_y = 9'(48 + 16 * r);
            probe_at(72 + 64 * c, 48 + 16 * r);
            tick(1'b1, 1'b0, 1'b1, 16'(10 * k), 6'(32 - k));
         end
      end
      check("clear_flag", 32'(level_clear), 1);
      check("clear_left", 32'(bricks_left), 0);
      tick(1'b0, 1'b0, 1'b0, 16'd0, 6'd0);
      @(negedge clk); restart = 1'b1;
      @(negedge clk); restart = 1'b0;
      check("reload_flag", 32'(level_clear), 0);
      @(negedge clk);
      check("reload_left", 32'(bricks_left), 32);
      check("reload_score", 32'(score), 320);
      check("reload_flag2", 32'(level_clear), 0);
      pix(64, 48, 1'b1);

      // 5: score saturation and ignored restart in PLAY
      @(negedge clk); force dut.score_q = 16'hFFF8;
      @(negedge clk); release dut.score_q;
      ball_x = 10'd56; ball_y = 9'd48;
      probe_at(64, 48);
      tick(1'b1, 1'b0, 1'b1, 16'hFFFF, 6'd31);
      @(negedge clk); restart = 1'b1;
      @(negedge clk); restart = 1'b0;
      repeat (2) @(negedge clk);
      check("play_restart_left", 32'(bricks_left), 31);
      check("play_restart_score", 32'(score), 32'hFFFF);
      check("play_restart_flag", 32'(level_clear), 0);

      // 6: reset right after frame_tick cancels the pending retirement
      do_reset();
      ball_x = 10'd56; ball_y = 9'd48;
      probe_at(64, 48);
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0; rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("rst6_score", 32'(score), 0);
      check("rst6_left", 32'(bricks_left), 32);
      pix(64, 48, 1'b1);

      repeat (3) @(negedge clk);
      check("queues_drained", 32'(hit_q.size() + pix_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
